debouncer: RTL

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debouncer.sv | 101 ++++++++++
 1 files changed

// File: rtl/debouncer.sv
// Push-button / switch debouncer: multi-flop synchronizer followed by a
// four-state qualification FSM that only accepts levels held for STABLE_CYCLES.
module debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_sig,
  output logic deb_sig,
  output logic settling
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_sig;
  state_t                 state_q, state_n;
  logic [CW-1:0]          count_q, count_n;
  logic                   deb_n, settling_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_sig};
    end
  end

  assign sync_sig = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= STABLE_LOW;
      count_q  <= '0;
      deb_sig  <= 1'b0;
      settling <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      deb_sig  <= deb_n;
      settling <= settling_n;
    end
  end

  always_comb begin
    state_n = state_q;
    count_n = '0;
    unique case (state_q)
      STABLE_LOW: begin
        if (sync_sig) begin
          state_n = WAIT_HIGH;
          count_n = CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync_sig) begin
          state_n = STABLE_LOW;
        end else if (count_q == LAST_COUNT) begin
          state_n = STABLE_HIGH;
        end else begin
          count_n = count_q + CW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync_sig) begin
          state_n = WAIT_LOW;
          count_n = CW'(1);
        end
      end
      WAIT_LOW: begin
        if (sync_sig) begin
          state_n = STABLE_HIGH;
        end else if (count_q == LAST_COUNT) begin
          state_n = STABLE_LOW;
        end else begin
          count_n = count_q + CW'(1);
        end
      end
      default: begin
        state_n = STABLE_LOW;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each is a
  // plain flop output that matches the state register cycle for cycle.
  always_comb begin
    deb_n      = (state_n == STABLE_HIGH) || (state_n == WAIT_LOW);
    settling_n = (state_n == WAIT_HIGH)   || (state_n == WAIT_LOW);
  end

endmodule
